// File: rtl/eq_monitor_pkg.sv
// Shared types for the equality window monitor.
// EQ_MONITOR_FIRST_MISS_EN adds first-miss fields to the summary.
package eq_monitor_pkg;

  localparam int MAX_CNT_W = 16;

  typedef enum logic {COLLECT, REPORT} state_t;

  typedef logic [MAX_CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t match_count;
    cnt_t max_run;
    logic run_hit;
`ifdef EQ_MONITOR_FIRST_MISS_EN
    cnt_t first_miss_idx;
    logic miss_seen;
`endif
  } summary_t;

  function automatic int cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/eq_window_monitor_if.sv
// Sample-in / summary-out bundle of the equality window monitor.
// EQ_MONITOR_FIRST_MISS_EN adds first_miss_idx and miss_seen.
interface eq_window_monitor_if #(
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             eq_in;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] max_run;
  logic             run_hit;
  logic             run_pulse;
`ifdef EQ_MONITOR_FIRST_MISS_EN
  logic [CNT_W-1:0] first_miss_idx;
  logic             miss_seen;
`endif

  modport master (
    output in_valid, eq_in, out_ready,
    input  in_ready, out_valid, match_count,
    input  max_run, run_hit, run_pulse
`ifdef EQ_MONITOR_FIRST_MISS_EN
    , input first_miss_idx, miss_seen
`endif
  );

  modport slave (
    input  in_valid, eq_in, out_ready,
    output in_ready, out_valid, match_count,
    output max_run, run_hit, run_pulse
`ifdef EQ_MONITOR_FIRST_MISS_EN
    , output first_miss_idx, miss_seen
`endif
  );
endinterface

// File: rtl/eq_run_tracker.sv
// Current/longest consecutive-match run with threshold pulse.
// max_nxt_o is the longest run including the sample accepted now.
module eq_run_tracker
  import eq_monitor_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int RUN_THRESH = 4,
  localparam int CNT_W = cnt_w(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             acc_i,
  input  logic             eq_i,
  output logic [CNT_W-1:0] max_nxt_o,
  output logic             pulse_o
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] THR = CNT_W'(RUN_THRESH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] run_inc;

  always_comb begin
    run_inc = (cur_q == SAT) ? SAT : cur_q + ONE;
    cur_d   = cur_q;
    max_d   = max_q;
    pulse_o = 1'b0;
    if (acc_i) begin
      if (eq_i) begin
        cur_d = run_inc;
        if (run_inc > max_q) max_d = run_inc;
        // a saturated run must not re-fire
        pulse_o = (run_inc == THR) && (cur_q != THR);
      end else begin
        cur_d = '0;
      end
    end
    max_nxt_o = max_d;
    if (clear_i) begin
      cur_d = '0;
      max_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      max_q <= '0;
    end else begin
      cur_q <= cur_d;
      max_q <= max_d;
    end
  end

endmodule

// File: rtl/eq_window_monitor.sv
// Windowed statistics over a stream of equality results.
// EQ_MONITOR_FIRST_MISS_EN enables first-miss index reporting.
module eq_window_monitor
  import eq_monitor_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int RUN_THRESH = 4,
  localparam int CNT_W = cnt_w(WINDOW)
) (
  input  logic               clk,
  input  logic               rst,
  eq_window_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] SAT  = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic             hit_q, hit_d;
  summary_t         sum_q, sum_d;
  logic             acc;
  logic             clear;
  logic             pulse;
  logic [CNT_W-1:0] max_nxt;

  assign acc   = bus.in_valid && in_ready_q;
  assign clear = out_valid_q && bus.out_ready;

  eq_run_tracker #(
    .WINDOW     (WINDOW),
    .RUN_THRESH (RUN_THRESH)
  ) u_run (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .acc_i     (acc),
    .eq_i      (bus.eq_in),
    .max_nxt_o (max_nxt),
    .pulse_o   (pulse)
  );

  always_comb begin
    idx_d   = idx_q;
    match_d = match_q;
    hit_d   = hit_q | pulse;
    if (acc) begin
      if (idx_q != SAT) idx_d = idx_q + ONE;
      if (bus.eq_in && match_q != SAT) match_d = match_q + ONE;
    end
    if (clear) begin
      idx_d   = '0;
      match_d = '0;
      hit_d   = 1'b0;
    end
  end

`ifdef EQ_MONITOR_FIRST_MISS_EN
  logic             miss_q, miss_d;
  logic [CNT_W-1:0] fmiss_q, fmiss_d;

  always_comb begin
    miss_d  = miss_q;
    fmiss_d = fmiss_q;
    if (acc && !bus.eq_in && !miss_q) begin
      miss_d  = 1'b1;
      fmiss_d = idx_q;
    end
    if (clear) begin
      miss_d  = 1'b0;
      fmiss_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_q  <= 1'b0;
      fmiss_q <= '0;
    end else begin
      miss_q  <= miss_d;
      fmiss_q <= fmiss_d;
    end
  end
`endif

  always_comb begin
    sum_d             = '0;
    sum_d.match_count = cnt_t'(match_d);
    sum_d.max_run     = cnt_t'(max_nxt);
    sum_d.run_hit     = hit_d;
`ifdef EQ_MONITOR_FIRST_MISS_EN
    sum_d.first_miss_idx = cnt_t'(fmiss_d);
    sum_d.miss_seen      = miss_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      match_q     <= '0;
      hit_q       <= 1'b0;
      sum_q       <= '0;
    end else begin
      idx_q   <= idx_d;
      match_q <= match_d;
      hit_q   <= hit_d;
      unique case (state_q)
        COLLECT: begin
          if (acc && idx_q == LAST) begin
            state_q     <= REPORT;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            sum_q       <= sum_d;
          end
        end
        REPORT: begin
          if (bus.out_ready) begin
            state_q     <= COLLECT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.match_count = sum_q.match_count[CNT_W-1:0];
  assign bus.max_run     = sum_q.max_run[CNT_W-1:0];
  assign bus.run_hit     = sum_q.run_hit;
  assign bus.run_pulse   = pulse;

  logic unused_hi;
`ifdef EQ_MONITOR_FIRST_MISS_EN
  assign bus.first_miss_idx = sum_q.first_miss_idx[CNT_W-1:0];
  assign bus.miss_seen      = sum_q.miss_seen;
  assign unused_hi = ^{sum_q.match_count[MAX_CNT_W-1:CNT_W],
                       sum_q.max_run[MAX_CNT_W-1:CNT_W],
                       sum_q.first_miss_idx[MAX_CNT_W-1:CNT_W]};
`else
  assign unused_hi = ^{sum_q.match_count[MAX_CNT_W-1:CNT_W],
                       sum_q.max_run[MAX_CNT_W-1:CNT_W]};
`endif

endmodule

// File: tb/tb_eq_window_monitor.sv
// Randomized bench for eq_window_monitor against a pattern model.
// EQ_MONITOR_FIRST_MISS_EN also checks the first-miss outputs.
module tb_eq_window_monitor;
  import eq_monitor_pkg::*;

  localparam int W  = 16;
  localparam int TH = 4;
  localparam int CW = cnt_w(W);

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  eq_window_monitor_if #(.CNT_W(CW)) bus ();

  eq_window_monitor #(
    .WINDOW     (W),
    .RUN_THRESH (TH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Length of the run of ones ending at sample i.
  function automatic int run_at(input logic [W-1:0] p, input int i);
    int r = 0;
    for (int j = i; j >= 0; j--) begin
      if (!p[j]) break;
      r++;
    end
    return r;
  endfunction

  function automatic int max_run_of(input logic [W-1:0] p);
    int m = 0;
    for (int i = 0; i < W; i++)
      if (run_at(p, i) > m) m = run_at(p, i);
    return m;
  endfunction

  function automatic int first_zero(input logic [W-1:0] p);
    for (int i = 0; i < W; i++)
      if (!p[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [W-1:0] p, input int n,
                      input int gap_pct);
    for (int i = 0; i < n; i++) begin
      int idle;
      idle = ($urandom_range(99) < gap_pct) ? $urandom_range(1, 3) : 0;
      repeat (idle) begin
        bus.in_valid = 1'b0;
        bus.eq_in    = 1'($urandom_range(1));
        @(negedge clk);
        chk("idle_pulse", 32'(bus.run_pulse), 0);
        tick();
      end
      bus.in_valid = 1'b1;
      bus.eq_in    = p[i];
      @(negedge clk);
      chk("in_ready", 32'(bus.in_ready), 1);
      chk("pulse", 32'(bus.run_pulse),
          32'(p[i] && run_at(p, i) == TH));
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_summary(input logic [W-1:0] p);
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 1);
    chk("in_ready_rep", 32'(bus.in_ready), 0);
    chk("match_count", 32'(bus.match_count), $countones(p));
    chk("max_run", 32'(bus.max_run), max_run_of(p));
    chk("run_hit", 32'(bus.run_hit), 32'(max_run_of(p) >= TH));
`ifdef EQ_MONITOR_FIRST_MISS_EN
    chk("miss_seen", 32'(bus.miss_seen), 32'(p != '1));
    chk("first_miss", 32'(bus.first_miss_idx), first_zero(p));
`endif
    tick();
  endtask

  task automatic release_report(input logic [W-1:0] p, input int hold,
                                input logic iv);
    bus.out_ready = 1'b0;
    bus.in_valid  = iv;
    bus.eq_in     = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_mc", 32'(bus.match_count), $countones(p));
      chk("hold_mr", 32'(bus.max_run), max_run_of(p));
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rel_valid", 32'(bus.out_valid), 1);
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("next_in_ready", 32'(bus.in_ready), 1);
    chk("next_valid", 32'(bus.out_valid), 0);
    tick();
  endtask

  task automatic window(input logic [W-1:0] p, input int gap_pct,
                        input int hold, input logic iv);
    feed(p, W, gap_pct);
    check_summary(p);
    release_report(p, hold, iv);
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_mc"}, 32'(bus.match_count), 0);
    chk({tag, "_mr"}, 32'(bus.max_run), 0);
    chk({tag, "_hit"}, 32'(bus.run_hit), 0);
    chk({tag, "_pulse"}, 32'(bus.run_pulse), 0);
`ifdef EQ_MONITOR_FIRST_MISS_EN
    chk({tag, "_miss"}, 32'(bus.miss_seen), 0);
    chk({tag, "_fmiss"}, 32'(bus.first_miss_idx), 0);
`endif
    tick();
  endtask

  initial begin
    logic [W-1:0] p;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.eq_in     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check_reset("rst");

    p = 16'h0008;
    window(p, 0, 0, 1'b0);
    p = 16'h00FC;
    window(p, 0, 2, 1'b0);
    p = 16'hFFFF;
    window(p, 0, 5, 1'b1);
    p = 16'h03C0;
    window(p, 50, 1, 1'b0);

    repeat (8) begin
      p = 16'($urandom);
      window(p, 30, $urandom_range(3), 1'($urandom_range(1)));
    end

    p = 16'hFFFF;
    feed(p, 9, 20);
    @(negedge clk);
    chk("no_early_valid", 32'(bus.out_valid), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("rst2");

    p = '0;
    window(p, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
